// File: rtl/axis_tx_pkg.sv
// axis_tx_pkg: shared constants, state encoding and pointer-width helper
// for the axis_frame_tx store-and-forward transmitter.
`default_nettype none

package axis_tx_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // A single-entry buffer still needs a one-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_frame_tx_if.sv
// axis_frame_tx_if: load port and outgoing stream of axis_frame_tx.
// master = transmitter side, slave = loader / stream consumer side.
`default_nettype none

interface axis_frame_tx_if #(
  parameter int DATA_W = 16
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (
    input  ld_valid, ld_data, ld_last, tready,
    output ld_ready, tvalid, tlast, tdata
  );

  modport slave (
    output ld_valid, ld_data, ld_last, tready,
    input  ld_ready, tvalid, tlast, tdata
  );
endinterface

`default_nettype wire

// File: rtl/axis_tx_buf.sv
// axis_tx_buf: DEPTH x DATA_W frame store, one synchronous write port and
// one asynchronous read port; contents are deliberately not reset.
`default_nettype none

module axis_tx_buf
  import axis_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [PTR_W-1:0]  waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [PTR_W-1:0]  raddr,
  output      logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/axis_frame_tx.sv
// axis_frame_tx: buffers one whole frame from the load port, then streams it
// out with tlast on the final word. Optional macro AXIS_FRAME_TX_CNT_EN adds frames_sent.
`default_nettype none

module axis_frame_tx
  import axis_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  axis_frame_tx_if.master   bus,
  output      logic         trunc,
  output      logic         done
`ifdef AXIS_FRAME_TX_CNT_EN
  ,
  output      logic [15:0]  frames_sent
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [0:0] ST_LOAD = 1'(LOAD);
  localparam logic [0:0] ST_SEND = 1'(SEND);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  len_m1_q, len_m1_d;
  logic              trunc_q, trunc_d;
  logic              done_q, done_d;
  logic              ld_fire;
  logic              tx_fire;
  logic              is_last;
  logic [DATA_W-1:0] rd_data;

  // Outputs decode only state and registered pointers, never tready/ld_valid.
  assign is_last      = (rd_ptr_q == len_m1_q);
  assign bus.ld_ready = (state_q == ST_LOAD);
  assign bus.tvalid   = (state_q == ST_SEND);
  assign bus.tlast    = (state_q == ST_SEND) && is_last;
  assign bus.tdata    = (state_q == ST_SEND) ? rd_data : '0;
  assign trunc        = trunc_q;
  assign done         = done_q;

  assign ld_fire = bus.ld_valid && (state_q == ST_LOAD);
  assign tx_fire = bus.tready && (state_q == ST_SEND);

  axis_tx_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (wr_ptr_q),
    .wdata (bus.ld_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_m1_d = len_m1_q;
    trunc_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (bus.ld_last || (wr_ptr_q == LAST_IDX)) begin
            state_d  = ST_SEND;
            len_m1_d = wr_ptr_q;
            rd_ptr_d = '0;
            trunc_d  = !bus.ld_last;
          end
        end
      end
      default: begin
        if (tx_fire) begin
          if (is_last) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_m1_q <= '0;
      trunc_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_m1_q <= len_m1_d;
      trunc_q  <= trunc_d;
      done_q   <= done_d;
    end
  end

`ifdef AXIS_FRAME_TX_CNT_EN
  logic [15:0] frames_sent_q, frames_sent_d;

  always_comb begin
    frames_sent_d = frames_sent_q;
    if (done_q) begin
      frames_sent_d = frames_sent_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_sent_q <= '0;
    end else begin
      frames_sent_q <= frames_sent_d;
    end
  end

  assign frames_sent = frames_sent_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_tx.sv
// tb_axis_frame_tx: directed self-checking bench for axis_frame_tx (DEPTH=16).
`default_nettype none

module tb_axis_frame_tx;

  logic clk = 1'b0;
  logic reset;
  logic trunc;
  logic done;
`ifdef AXIS_FRAME_TX_CNT_EN
  logic [15:0] frames_sent;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axis_frame_tx_if #(.DATA_W(16)) bus ();

  axis_frame_tx #(
    .DATA_W (16),
    .DEPTH  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .trunc       (trunc),
    .done        (done)
`ifdef AXIS_FRAME_TX_CNT_EN
    ,
    .frames_sent (frames_sent)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Presents one word per cycle; returns at the first cycle after the closing word.
  task automatic load_words(input logic [15:0] w[$], input bit last_on_end);
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data  = w[i];
      bus.ld_last  = last_on_end && (i == w.size() - 1);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_data  = 16'hDEAD;
    check("no_trunc", trunc, 0);
  endtask

  // mode 0: tready always high; mode 1: tready pattern 1,0,0,1,0,0,...
  task automatic recv(input logic [15:0] exp[$], input int mode, input int exp_cycles);
    int idx = 0;
    int cyc = 0;
    while (idx < exp.size() && cyc < 100) begin
      bus.tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      check("tvalid", bus.tvalid, 1);
      check("tdata", bus.tdata, exp[idx]);
      check("tlast", bus.tlast, (idx == exp.size() - 1));
      check("ld_ready_send", bus.ld_ready, 0);
      if (bus.tready) idx++;
      cyc++;
      @(negedge clk);
    end
    bus.tready = 1'b0;
    check("words_sent", idx, exp.size());
    check("send_cycles", cyc, exp_cycles);
    check("done", done, 1);
    check("tvalid_after", bus.tvalid, 0);
    check("tdata_idle", bus.tdata, 0);
    check("ld_ready_after", bus.ld_ready, 1);
    @(negedge clk);
    check("done_once", done, 0);
  endtask

  initial begin
    logic [15:0] f4[$];
    logic [15:0] f1[$];
    logic [15:0] f16[$];
    logic [15:0] fa[$];
    logic [15:0] fb[$];

    f4 = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    f1 = '{16'hBEEF};
    for (int i = 0; i < 16; i++) f16.push_back(16'h0100 + 16'(i));
    fa = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    fb = '{16'h0011, 16'h0022, 16'h0033};

    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.tready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_tvalid", bus.tvalid, 0);
    check("rst_tlast", bus.tlast, 0);
    check("rst_tdata", bus.tdata, 0);
    check("rst_trunc", trunc, 0);
    check("rst_done", done, 0);
`ifdef AXIS_FRAME_TX_CNT_EN
    check("rst_frames", frames_sent, 0);
`endif
    reset = 1'b1;

    // Four-word frame, no backpressure
    load_words(f4, 1'b1);
    recv(f4, 0, 4);

    // Same frame under tready 1,0,0 pattern
    load_words(f4, 1'b1);
    recv(f4, 1, 10);

    // Single-word frame
    load_words(f1, 1'b1);
    recv(f1, 0, 1);

    // 17 words without ld_last: closes at 16 with trunc
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data  = f16[i];
      bus.ld_last  = 1'b0;
    end
    @(negedge clk);
    check("trunc_ld_ready", bus.ld_ready, 0);
    check("trunc_pulse", trunc, 1);
    check("trunc_tvalid", bus.tvalid, 1);
    bus.ld_data = 16'h0117;
    @(negedge clk);
    check("trunc_once", trunc, 0);
    check("trunc_hold", bus.tdata, 16'h0100);
    bus.ld_valid = 1'b0;
    recv(f16, 0, 16);

    // Asynchronous reset while word 3 is on the stream
    load_words(fa, 1'b1);
    bus.tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_word3", bus.tdata, 16'h00A3);
    reset = 1'b0;
    #1;
    check("arst_tvalid", bus.tvalid, 0);
    check("arst_ld_ready", bus.ld_ready, 1);
    check("arst_tdata", bus.tdata, 0);
    bus.tready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    load_words(fb, 1'b1);
    recv(fb, 0, 3);

`ifdef AXIS_FRAME_TX_CNT_EN
    check("frames_1", frames_sent, 1);
    load_words(f1, 1'b1);
    recv(f1, 0, 1);
    load_words(f4, 1'b1);
    recv(f4, 0, 4);
    check("frames_3", frames_sent, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
